// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection and bubble insertion.
// Optional write-before-read bypass from WB is enabled by defining ID_WB_BYPASS_EN.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_readData1,
    input  logic [DATA_W-1:0] id_readData2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [7:0]        id_ctrl,
    input  logic              flush,
    input  logic              wb_regWrite,
    input  logic [REG_AW-1:0] wb_writeRegister,
    input  logic [DATA_W-1:0] wb_writeData,
    output logic              stall,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_writeReg,
    output logic [DATA_W-1:0] ex_opA,
    output logic [DATA_W-1:0] ex_opB,
    output logic [DATA_W-1:0] ex_imm,
    output logic [7:0]        ex_ctrl
);

    localparam int CTRL_MEMREAD = 5;
    localparam int CTRL_REGDST  = 2;

    logic              r_valid;
    logic [REG_AW-1:0] r_rs, r_rt, r_wreg;
    logic [DATA_W-1:0] r_opA, r_opB, r_imm;
    logic [7:0]        r_ctrl;

    logic              w_stall;
    logic              w_bubble;
    logic [REG_AW-1:0] w_wreg;
    logic [DATA_W-1:0] w_opA, w_opB;

    // Register $0 in EX never produces a hazard: the load result is discarded.
    assign w_stall = r_valid & r_ctrl[CTRL_MEMREAD] & (r_wreg != '0) & id_valid & ~flush
                   & ((id_rs == r_wreg) | (id_rt == r_wreg));

    assign w_bubble = ~id_valid | flush | w_stall;
    assign w_wreg   = id_ctrl[CTRL_REGDST] ? id_rd : id_rt;

    always_comb begin
        w_opA = id_readData1;
        w_opB = id_readData2;
`ifdef ID_WB_BYPASS_EN
        if (wb_regWrite && (wb_writeRegister != '0) && (wb_writeRegister == id_rs))
            w_opA = wb_writeData;
        if (wb_regWrite && (wb_writeRegister != '0) && (wb_writeRegister == id_rt))
            w_opB = wb_writeData;
`endif
        // $0 reads as zero regardless of what the file or bypass offers.
        if (id_rs == '0) w_opA = '0;
        if (id_rt == '0) w_opB = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_wreg  <= '0;
            r_opA   <= '0;
            r_opB   <= '0;
            r_imm   <= '0;
            r_ctrl  <= '0;
        end else if (w_bubble) begin
            r_valid <= 1'b0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_wreg  <= '0;
            r_opA   <= '0;
            r_opB   <= '0;
            r_imm   <= '0;
            r_ctrl  <= '0;
        end else begin
            r_valid <= 1'b1;
            r_rs    <= id_rs;
            r_rt    <= id_rt;
            r_wreg  <= w_wreg;
            r_opA   <= w_opA;
            r_opB   <= w_opB;
            r_imm   <= id_imm;
            r_ctrl  <= id_ctrl;
        end
    end

`ifndef ID_WB_BYPASS_EN
    // WB port is only consumed by the bypass path.
    logic w_unused_wb;
    assign w_unused_wb = ^{wb_regWrite, wb_writeRegister, wb_writeData};
`endif

    assign stall       = w_stall;
    assign ex_valid    = r_valid;
    assign ex_rs       = r_rs;
    assign ex_rt       = r_rt;
    assign ex_writeReg = r_wreg;
    assign ex_opA      = r_opA;
    assign ex_opB      = r_opB;
    assign ex_imm      = r_imm;
    assign ex_ctrl     = r_ctrl;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, latching, regDst, load-use stall,
// flush priority, bypass (either build), zero register and mid-stream reset.
module tb_id_ex_stage;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [AW-1:0] id_rs, id_rt, id_rd;
    logic [DW-1:0] id_readData1, id_readData2, id_imm;
    logic [7:0]    id_ctrl;
    logic          flush;
    logic          wb_regWrite;
    logic [AW-1:0] wb_writeRegister;
    logic [DW-1:0] wb_writeData;
    logic          stall, ex_valid;
    logic [AW-1:0] ex_rs, ex_rt, ex_writeReg;
    logic [DW-1:0] ex_opA, ex_opB, ex_imm;
    logic [7:0]    ex_ctrl;

    int n_checks = 0;
    int n_fail   = 0;

    // ctrl = {regWrite, memToReg, memRead, memWrite, aluSrc, regDst, aluOp[1:0]}
    localparam logic [7:0] CTRL_LW  = 8'hE8; // regWrite memToReg memRead aluSrc
    localparam logic [7:0] CTRL_ADD = 8'h86; // regWrite regDst aluOp=10

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_readData1(id_readData1), .id_readData2(id_readData2), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .flush(flush),
        .wb_regWrite(wb_regWrite), .wb_writeRegister(wb_writeRegister), .wb_writeData(wb_writeData),
        .stall(stall), .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_writeReg(ex_writeReg), .ex_opA(ex_opA), .ex_opB(ex_opB),
        .ex_imm(ex_imm), .ex_ctrl(ex_ctrl)
    );

    task automatic idle_inputs();
        id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_readData1 = 0; id_readData2 = 0; id_imm = 0; id_ctrl = 0;
        flush = 0; wb_regWrite = 0; wb_writeRegister = 0; wb_writeData = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drive(input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                         input logic [DW-1:0] d1, input logic [DW-1:0] d2, input logic [DW-1:0] imm,
                         input logic [7:0] ctrl);
        id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd;
        id_readData1 = d1; id_readData2 = d2; id_imm = imm; id_ctrl = ctrl;
    endtask

    task automatic test_reset();
        rst = 0; idle_inputs();
        #3;
        n_checks++;
        if ({ex_valid, ex_ctrl, ex_rs, ex_rt, ex_writeReg, ex_opA, ex_opB, ex_imm} !== '0) begin
            n_fail++; $display("FAIL reset_bundle got valid=%b ctrl=%h opA=%h", ex_valid, ex_ctrl, ex_opA);
        end
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", stall); end
        repeat (2) @(negedge clk);
        rst = 1;
        step();
    endtask

    task automatic test_latch();
        drive(5'd4, 5'd6, 5'd7, 32'hAAAA_0001, 32'hBBBB_0002, 32'hFFFF_FFF0, CTRL_ADD);
        step();
        n_checks++;
        if ({ex_valid, ex_rs, ex_rt, ex_writeReg} !== {1'b1, 5'd4, 5'd6, 5'd7}) begin
            n_fail++; $display("FAIL latch_regs got v=%b rs=%0d rt=%0d wr=%0d exp v=1 rs=4 rt=6 wr=7",
                               ex_valid, ex_rs, ex_rt, ex_writeReg);
        end
        n_checks++;
        if ({ex_opA, ex_opB, ex_imm, ex_ctrl} !== {32'hAAAA_0001, 32'hBBBB_0002, 32'hFFFF_FFF0, CTRL_ADD}) begin
            n_fail++; $display("FAIL latch_data got A=%h B=%h imm=%h ctrl=%h", ex_opA, ex_opB, ex_imm, ex_ctrl);
        end
        idle_inputs();
        step();
        n_checks++;
        if ({ex_valid, ex_ctrl, ex_opA} !== '0) begin
            n_fail++; $display("FAIL idle_bubble got v=%b ctrl=%h A=%h exp all 0", ex_valid, ex_ctrl, ex_opA);
        end
    endtask

    task automatic test_regdst();
        drive(5'd1, 5'd3, 5'd12, 32'h1, 32'h2, 32'h0, 8'h84);
        step();
        n_checks++;
        if (ex_writeReg !== 5'd12) begin n_fail++; $display("FAIL regdst1 got=%0d exp=12", ex_writeReg); end
        drive(5'd1, 5'd3, 5'd12, 32'h1, 32'h2, 32'h0, 8'h80);
        step();
        n_checks++;
        if (ex_writeReg !== 5'd3) begin n_fail++; $display("FAIL regdst0 got=%0d exp=3", ex_writeReg); end
        idle_inputs(); step();
    endtask

    task automatic test_load_use();
        drive(5'd29, 5'd8, 5'd0, 32'h1000, 32'h0, 32'h4, CTRL_LW); // lw $8, 4($29)
        step();
        drive(5'd8, 5'd10, 5'd9, 32'h11, 32'h22, 32'h0, CTRL_ADD); // add $9,$8,$10
        #1;
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL loaduse_stall got=%b exp=1", stall); end
        step();
        n_checks++;
        if ({ex_valid, ex_ctrl} !== 9'h0) begin
            n_fail++; $display("FAIL loaduse_bubble got v=%b ctrl=%h exp v=0 ctrl=00", ex_valid, ex_ctrl);
        end
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL loaduse_stall_once got=%b exp=0", stall); end
        step();
        n_checks++;
        if ({ex_valid, ex_writeReg, ex_ctrl, ex_opA} !== {1'b1, 5'd9, CTRL_ADD, 32'h11}) begin
            n_fail++; $display("FAIL loaduse_add got v=%b wr=%0d ctrl=%h A=%h exp v=1 wr=9 ctrl=86 A=11",
                               ex_valid, ex_writeReg, ex_ctrl, ex_opA);
        end
        // rt operand also triggers the hazard
        drive(5'd29, 5'd8, 5'd0, 32'h1000, 32'h0, 32'h4, CTRL_LW);
        step();
        drive(5'd10, 5'd8, 5'd9, 32'h11, 32'h22, 32'h0, CTRL_ADD);
        #1;
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL loaduse_rt_stall got=%b exp=1", stall); end
        // no hazard when neither source matches
        drive(5'd10, 5'd11, 5'd9, 32'h11, 32'h22, 32'h0, CTRL_ADD);
        #1;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL nohazard_stall got=%b exp=0", stall); end
        idle_inputs(); step();
    endtask

    task automatic test_flush_priority();
        drive(5'd29, 5'd8, 5'd0, 32'h1000, 32'h0, 32'h4, CTRL_LW);
        step();
        drive(5'd8, 5'd10, 5'd9, 32'h11, 32'h22, 32'h0, CTRL_ADD);
        flush = 1;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got=%b exp=0", stall); end
        step();
        n_checks++;
        if ({ex_valid, ex_ctrl, ex_writeReg} !== '0) begin
            n_fail++; $display("FAIL flush_bubble got v=%b ctrl=%h wr=%0d exp 0", ex_valid, ex_ctrl, ex_writeReg);
        end
        idle_inputs(); step();
    endtask

    task automatic test_bypass();
        logic [DW-1:0] exp_a;
`ifdef ID_WB_BYPASS_EN
        exp_a = 32'h1234;
`else
        exp_a = 32'hDEAD;
`endif
        drive(5'd5, 5'd6, 5'd7, 32'hDEAD, 32'hBEEF, 32'h0, CTRL_ADD);
        wb_regWrite = 1; wb_writeRegister = 5'd5; wb_writeData = 32'h1234;
        step();
        n_checks++;
        if (ex_opA !== exp_a) begin n_fail++; $display("FAIL bypass_opA got=%h exp=%h", ex_opA, exp_a); end
        n_checks++;
        if (ex_opB !== 32'hBEEF) begin n_fail++; $display("FAIL bypass_opB got=%h exp=beef", ex_opB); end
        idle_inputs(); step();
    endtask

    task automatic test_zero_reg();
        drive(5'd0, 5'd0, 5'd4, 32'h77, 32'h88, 32'h0, CTRL_ADD);
        wb_regWrite = 1; wb_writeRegister = 5'd0; wb_writeData = 32'hFFFF_FFFF;
        step();
        n_checks++;
        if ({ex_opA, ex_opB} !== 64'h0) begin
            n_fail++; $display("FAIL zero_ops got A=%h B=%h exp 0", ex_opA, ex_opB);
        end
        idle_inputs();
        drive(5'd29, 5'd0, 5'd0, 32'h1000, 32'h0, 32'h4, CTRL_LW); // lw $0
        step();
        drive(5'd0, 5'd0, 5'd9, 32'h1, 32'h2, 32'h0, CTRL_ADD);
        #1;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL zero_stall got=%b exp=0", stall); end
        idle_inputs(); step();
    endtask

    task automatic test_reset_midstream();
        drive(5'd29, 5'd8, 5'd0, 32'h1000, 32'h0, 32'h4, CTRL_LW);
        step();
        drive(5'd8, 5'd10, 5'd9, 32'h11, 32'h22, 32'h0, CTRL_ADD);
        #2;
        rst = 0;
        #1;
        n_checks++;
        if ({ex_valid, ex_ctrl, ex_rs, ex_rt, ex_writeReg, ex_opA, ex_opB, ex_imm} !== '0) begin
            n_fail++; $display("FAIL midreset_bundle got v=%b ctrl=%h wr=%0d imm=%h", ex_valid, ex_ctrl, ex_writeReg, ex_imm);
        end
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL midreset_stall got=%b exp=0", stall); end
        @(negedge clk);
        rst = 1;
        step();
        n_checks++;
        if ({ex_valid, ex_writeReg, ex_opB} !== {1'b1, 5'd9, 32'h22}) begin
            n_fail++; $display("FAIL midreset_release got v=%b wr=%0d B=%h exp v=1 wr=9 B=22", ex_valid, ex_writeReg, ex_opB);
        end
        idle_inputs(); step();
    endtask

    initial begin
        test_reset();
        test_latch();
        test_regdst();
        test_load_use();
        test_flush_priority();
        test_bypass();
        test_zero_reg();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
